// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg7_scan_driver_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NUM_DIG = 4;

  // Active-high glyphs, bit0=a ... bit6=g
  localparam logic [SEG_W-1:0] GLYPH_0    = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1    = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2    = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3    = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4    = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5    = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6    = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7    = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8    = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9    = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'h00;

  // Digit slot index; value equals the anode bit position
  typedef enum logic [1:0] {
    DIG_SEC_U = 2'd0,
    DIG_SEC_T = 2'd1,
    DIG_MIN_U = 2'd2,
    DIG_MIN_T = 2'd3
  } dig_e;

  // One coherent display frame
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_unit;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_unit;
  } frame_t;

  // Pick the BCD digit shown in a given slot
  function automatic logic [DIGIT_W-1:0] digit_sel(input frame_t f, input dig_e i);
    logic [DIGIT_W-1:0] d;
    case (i)
      DIG_SEC_U: d = f.sec_unit;
      DIG_SEC_T: d = f.sec_tens;
      DIG_MIN_U: d = f.min_unit;
      default:   d = f.min_tens;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit bus from the timer plus the display pins.
interface seg7_scan_driver_if;
  logic       enable;
  logic       dp_en;
  logic [3:0] sec_unit;
  logic [3:0] sec_tens;
  logic [3:0] min_unit;
  logic [3:0] min_tens;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output enable, dp_en, sec_unit, sec_tens, min_unit, min_tens,
    input  seg, dp, an
  );

  modport slave (
    input  enable, dp_en, sec_unit, sec_tens, min_unit, min_tens,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD to active-high seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [SEG_W-1:0]   glyph_c
);

  // Glyph lookup
  always_comb begin
    glyph_c = GLYPH_DASH;
    case (bcd)
      4'd0: glyph_c = GLYPH_0;
      4'd1: glyph_c = GLYPH_1;
      4'd2: glyph_c = GLYPH_2;
      4'd3: glyph_c = GLYPH_3;
      4'd4: glyph_c = GLYPH_4;
      4'd5: glyph_c = GLYPH_5;
      4'd6: glyph_c = GLYPH_6;
      4'd7: glyph_c = GLYPH_7;
      4'd8: glyph_c = GLYPH_8;
      4'd9: glyph_c = GLYPH_9;
      default: glyph_c = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment driver with frame capture,
// leading-zero blanking, ghosting guard band and colon output.
// DIV = CLK_FREQ_HZ/SCAN_HZ must be at least GHOST_CYCLES+2.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ        = 50_000_000,
  parameter int unsigned SCAN_HZ            = 4_000,
  parameter int unsigned GHOST_CYCLES       = 16,
  parameter int unsigned COMMON_ANODE       = 1,
  parameter int unsigned BLANK_LEADING_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic        INV = (COMMON_ANODE != 0);
  localparam logic [NUM_DIG-1:0] AN_OFF  = {NUM_DIG{INV}};
  localparam logic [SEG_W-1:0]   SEG_OFF = {SEG_W{INV}};

  logic [PW-1:0]      presc_q, presc_d;
  dig_e               idx_q, idx_d;
  frame_t             s1_q, s2_q, shadow_q, shadow_d;
  frame_t             bus_c;
  logic               tick_c;
  logic [DIGIT_W-1:0] digit_c;
  logic [SEG_W-1:0]   glyph_c;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;

  assign bus_c = '{min_tens: bus.min_tens, min_unit: bus.min_unit,
                   sec_tens: bus.sec_tens, sec_unit: bus.sec_unit};
  assign tick_c  = (presc_q == PW'(DIV - 1));
  assign digit_c = digit_sel(shadow_q, idx_q);

  bcd_to_seg7 u_dec (
    .bcd     (digit_c),
    .glyph_c (glyph_c)
  );

  // Next prescaler, slot index and shadow frame (loaded only at a stable frame boundary)
  always_comb begin
    presc_d  = presc_q + PW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick_c) begin
      presc_d = '0;
      idx_d   = dig_e'(2'(idx_q + 2'd1));
      if ((idx_q == DIG_MIN_T) && (s1_q == s2_q)) begin
        shadow_d = s2_q;
      end
    end
  end

  // Next pin values in active-high form, polarity applied once at the end
  always_comb begin
    logic [NUM_DIG-1:0] an_ah;
    logic [SEG_W-1:0]   seg_ah;
    logic               dp_ah;
    an_ah  = '0;
    seg_ah = GLYPH_OFF;
    dp_ah  = 1'b0;
    if (bus.enable) begin
      if (presc_q >= PW'(GHOST_CYCLES)) begin
        an_ah = NUM_DIG'(1) << idx_q;
      end
      seg_ah = glyph_c;
      if ((BLANK_LEADING_ZERO != 0) && (idx_q == DIG_MIN_T) && (shadow_q.min_tens == '0)) begin
        seg_ah = GLYPH_OFF;
      end
      dp_ah = bus.dp_en && (idx_q == DIG_MIN_U);
    end
    an_d  = an_ah ^ AN_OFF;
    seg_d = seg_ah ^ SEG_OFF;
    dp_d  = dp_ah ^ INV;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= DIG_SEC_U;
      s1_q     <= '0;
      s2_q     <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= INV;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      s1_q     <= bus_c;
      s2_q     <= s1_q;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-based display model.
module tb_seg7_scan_driver;

  localparam int DIV   = 10;
  localparam int GHOST = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, dp_en;
  logic [3:0] sec_unit, sec_tens, min_unit, min_tens;

  int vectors = 0;
  int miscompares = 0;

  seg7_scan_driver_if ifa ();
  seg7_scan_driver_if ifb ();

  assign ifa.enable = enable;   assign ifb.enable = enable;
  assign ifa.dp_en = dp_en;     assign ifb.dp_en = dp_en;
  assign ifa.sec_unit = sec_unit; assign ifb.sec_unit = sec_unit;
  assign ifa.sec_tens = sec_tens; assign ifb.sec_tens = sec_tens;
  assign ifa.min_unit = min_unit; assign ifb.min_unit = min_unit;
  assign ifa.min_tens = min_tens; assign ifb.min_tens = min_tens;

  seg7_scan_driver #(.CLK_FREQ_HZ(1000), .SCAN_HZ(100), .GHOST_CYCLES(GHOST),
                     .COMMON_ANODE(1), .BLANK_LEADING_ZERO(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));

  seg7_scan_driver #(.CLK_FREQ_HZ(1000), .SCAN_HZ(100), .GHOST_CYCLES(GHOST),
                     .COMMON_ANODE(1), .BLANK_LEADING_ZERO(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  // Segment letters lit for each decimal digit
  string glyph_txt [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] letters(input string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    if (d > 4'd9) return letters("g");
    return letters(glyph_txt[d]);
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: display state derived from cycles since reset release
  int         t;
  logic [15:0] frame, h1, h2;
  logic [3:0] exp_an;
  logic [6:0] exp_seg_a, exp_seg_b;
  logic       exp_dp;
  bit         model_valid = 0;

  always @(posedge clk) begin
    int p, ix;
    logic [6:0] g;
    if (reset) begin
      exp_an = 4'b1111; exp_seg_a = 7'h7F; exp_seg_b = 7'h7F; exp_dp = 1'b1;
      t = 0; frame = '0; h1 = '0; h2 = '0;
    end else begin
      p  = t % DIV;
      ix = (t / DIV) % 4;
      g  = glyph(frame[4*ix +: 4]);
      if (enable) begin
        exp_an    = (p >= GHOST) ? ~(4'b0001 << ix) : 4'b1111;
        exp_seg_b = ~g;
        exp_seg_a = (ix == 3 && frame[15:12] == 4'd0) ? 7'h7F : ~g;
        exp_dp    = ~(dp_en && ix == 2);
      end else begin
        exp_an = 4'b1111; exp_seg_a = 7'h7F; exp_seg_b = 7'h7F; exp_dp = 1'b1;
      end
      if (p == DIV - 1 && ix == 3 && h1 == h2) frame = h2;
      h2 = h1;
      h1 = {min_tens, min_unit, sec_tens, sec_unit};
      t++;
    end
    model_valid = 1;
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("an_a",  {4'b0, ifa.an},  {4'b0, exp_an});
      cmp("seg_a", {1'b0, ifa.seg}, {1'b0, exp_seg_a});
      cmp("dp_a",  {7'b0, ifa.dp},  {7'b0, exp_dp});
      cmp("an_b",  {4'b0, ifb.an},  {4'b0, exp_an});
      cmp("seg_b", {1'b0, ifb.seg}, {1'b0, exp_seg_b});
      cmp("dp_b",  {7'b0, ifb.dp},  {7'b0, exp_dp});
    end
  end

  task automatic wait_an(input logic [3:0] target, input int budget);
    int n = 0;
    while (ifa.an !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ifa.an !== target) cmp("wait_an", {4'b0, ifa.an}, {4'b0, target});
  endtask

  task automatic set_digits(input logic [3:0] mt, mu, st, su);
    min_tens = mt; min_unit = mu; sec_tens = st; sec_unit = su;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; dp_en = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) @(negedge clk);
    cmp("rst_an",  {4'b0, ifa.an},  8'h0F);
    cmp("rst_seg", {1'b0, ifa.seg}, 8'h7F);
    cmp("rst_dp",  {7'b0, ifa.dp},  8'h01);
    reset = 1'b0;

    // Guard band after release, then cleared frame shows 0 on digit 0
    repeat (2) @(negedge clk);
    cmp("guard_an", {4'b0, ifa.an}, 8'h0F);
    @(negedge clk);
    cmp("first_an",  {4'b0, ifa.an},  8'h0E);
    cmp("first_seg", {1'b0, ifa.seg}, 8'h40);

    // First frame loaded at the end of slot 3; digit 0 now shows 4
    repeat (40) @(negedge clk);
    cmp("frame_an",  {4'b0, ifa.an},  8'h0E);
    cmp("frame_seg", {1'b0, ifa.seg}, 8'h19);

    // Leading-zero blanking versus no blanking
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    repeat (80) @(negedge clk);
    wait_an(4'b0111, 50);
    cmp("blank_a", {1'b0, ifa.seg}, 8'h7F);
    cmp("blank_b", {1'b0, ifb.seg}, 8'h40);
    wait_an(4'b1011, 50);
    cmp("min_unit5", {1'b0, ifa.seg}, 8'h12);

    // Invalid code shows a dash
    sec_unit = 4'hB;
    repeat (80) @(negedge clk);
    wait_an(4'b1110, 50);
    cmp("dash", {1'b0, ifa.seg}, 8'h3F);

    // Unstable bus never loads; stable value loads at the next boundary
    for (int i = 0; i < 20; i++) begin
      sec_unit = 4'(i % 10);
      @(negedge clk);
    end
    sec_unit = 4'd7;
    repeat (80) @(negedge clk);
    wait_an(4'b1110, 50);
    cmp("held7", {1'b0, ifa.seg}, 8'h78);

    // Colon on digit 2 only; enable drop mid-slot
    dp_en = 1'b1;
    wait_an(4'b1011, 50);
    cmp("dp_on", {7'b0, ifa.dp}, 8'h00);
    wait_an(4'b1110, 50);
    cmp("dp_off", {7'b0, ifa.dp}, 8'h01);
    wait_an(4'b1011, 50);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    cmp("dis_an",  {4'b0, ifa.an},  8'h0F);
    cmp("dis_seg", {1'b0, ifa.seg}, 8'h7F);
    cmp("dis_dp",  {7'b0, ifa.dp},  8'h01);
    repeat (25) @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);

    // Randomized traffic including a mid-scan reset
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_digits(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) dp_en = ~dp_en;
      reset = (c == 700 || c == 701);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
